// File: rtl/control_unit_pipe.sv
// control_unit_pipe: pipelined RV32I control decoder with E/M/W control registers.
// Optional sticky illegal-instruction trap is enabled by defining CTRL_ILLEGAL_TRAP_EN.
module control_unit_pipe #(
    parameter int ALUCTRL_W             = 4,
    parameter int FLUSH_ON_RESET_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [1:0]           ImmSrcD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 PCSrcE,
    output logic                 ResultSrcE0,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic                 IllegalD
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 IllegalSeen
`endif
);

    localparam int CW = $clog2(FLUSH_ON_RESET_CYCLES + 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef struct packed {
        logic                 reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic                 alu_src;
        logic [ALUCTRL_W-1:0] alu_ctrl;
    } ctrl_t;

    ctrl_t          dec_d;
    ctrl_t          ctl_e;
    logic [3:0]     alu_d;
    logic [2:0]     funct3_e;
    logic [CW-1:0]  rst_cnt;
    logic           f7_checked;
    logic           cond;
    logic           trap_q;
    logic           reg_write_m;
    logic           mem_write_m;
    logic [1:0]     result_src_m;
    logic           reg_write_w;
    logic [1:0]     result_src_w;

    // I-type only constrains funct7 for the shift-immediate forms
    assign f7_checked = (op == OP_R) || (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        dec_d    = '0;
        alu_d    = ALU_ADD;
        ImmSrcD  = 2'b00;
        IllegalD = 1'b0;
        unique case (op)
            OP_LOAD: begin
                dec_d.reg_write  = 1'b1;
                dec_d.result_src = 2'b01;
                dec_d.alu_src    = 1'b1;
            end
            OP_STORE: begin
                dec_d.mem_write = 1'b1;
                dec_d.alu_src   = 1'b1;
                ImmSrcD         = 2'b01;
            end
            OP_R, OP_I: begin
                dec_d.reg_write = 1'b1;
                dec_d.alu_src   = (op == OP_I);
                unique case (funct3)
                    3'b000: alu_d = ALU_ADD;
                    3'b001: alu_d = ALU_SLL;
                    3'b010: alu_d = ALU_SLT;
                    3'b011: alu_d = ALU_SLTU;
                    3'b100: alu_d = ALU_XOR;
                    3'b101: alu_d = ALU_SRL;
                    3'b110: alu_d = ALU_OR;
                    3'b111: alu_d = ALU_AND;
                endcase
                if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b101)
                        alu_d = ALU_SRA;
                    else if (funct3 == 3'b000 && op == OP_R)
                        alu_d = ALU_SUB;
                    else if (f7_checked)
                        IllegalD = 1'b1;
                end else if (funct7 != 7'b0 && f7_checked) begin
                    IllegalD = 1'b1;
                end
            end
            OP_BR: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    IllegalD = 1'b1;
                end else begin
                    dec_d.branch = 1'b1;
                    alu_d        = ALU_SUB;
                    ImmSrcD      = 2'b10;
                end
            end
            OP_JAL: begin
                dec_d.jump       = 1'b1;
                dec_d.reg_write  = 1'b1;
                dec_d.result_src = 2'b10;
                ImmSrcD          = 2'b11;
            end
            OP_JALR: begin
                dec_d.jump       = 1'b1;
                dec_d.reg_write  = 1'b1;
                dec_d.result_src = 2'b10;
                dec_d.alu_src    = 1'b1;
            end
            OP_NOP: ;
            default: IllegalD = 1'b1;
        endcase
        dec_d.alu_ctrl = ALUCTRL_W'(alu_d);
        if (IllegalD) begin
            dec_d   = '0;
            ImmSrcD = 2'b00;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)
            trap_q <= 1'b0;
        else if (IllegalD && !StallE && !FlushE)
            trap_q <= 1'b1;
    end
    assign IllegalSeen = trap_q;
`else
    assign trap_q = 1'b0;
`endif

    // E stage: the post-reset counter forces bubbles until the front end settles
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_e    <= '0;
            funct3_e <= '0;
            rst_cnt  <= CW'(FLUSH_ON_RESET_CYCLES);
        end else begin
            if (rst_cnt != '0)
                rst_cnt <= rst_cnt - CW'(1);
            if (FlushE || rst_cnt != '0) begin
                ctl_e    <= '0;
                funct3_e <= '0;
            end else if (!StallE) begin
                ctl_e    <= trap_q ? '0 : dec_d;
                funct3_e <= funct3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
        end else if (!StallE) begin
            reg_write_m  <= ctl_e.reg_write;
            mem_write_m  <= ctl_e.mem_write;
            result_src_m <= ctl_e.result_src;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
        end
    end

    always_comb begin
        cond = 1'b0;
        unique case (funct3_e)
            3'b000:  cond = ZeroE;
            3'b001:  cond = !ZeroE;
            3'b100:  cond = LtE;
            3'b101:  cond = !LtE;
            3'b110:  cond = LtuE;
            3'b111:  cond = !LtuE;
            default: cond = 1'b0;
        endcase
    end

    assign PCSrcE      = ctl_e.jump | (ctl_e.branch & cond);
    assign ALUControlE = ctl_e.alu_ctrl;
    assign ALUSrcE     = ctl_e.alu_src;
    assign ResultSrcE0 = ctl_e.result_src[0];
    assign RegWriteM   = reg_write_m;
    assign MemWriteM   = mem_write_m;
    assign RegWriteW   = reg_write_w;
    assign ResultSrcW  = result_src_w;

endmodule

// File: tb/tb_control_unit_pipe.sv
// tb_control_unit_pipe: table vectors, directed pipeline sequences and a
// randomized run against a stage-by-stage behavioural model.
`timescale 1ns/1ps
module tb_control_unit_pipe;
    localparam int W    = 4;
    localparam int NRST = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] op = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic StallE = 0, FlushE = 0, ZeroE = 0, LtE = 0, LtuE = 0;
    logic [1:0] ImmSrcD, ResultSrcW;
    logic [W-1:0] ALUControlE;
    logic ALUSrcE, PCSrcE, ResultSrcE0, RegWriteM, MemWriteM, RegWriteW, IllegalD;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic IllegalSeen;
`endif

    int n_vec = 0;
    int n_err = 0;

    control_unit_pipe #(.ALUCTRL_W(W), .FLUSH_ON_RESET_CYCLES(NRST)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .IllegalD(IllegalD)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .IllegalSeen(IllegalSeen)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ill;
        logic [1:0] imm;
        logic       rw;
        logic [1:0] rs;
        logic       mw, jmp, br, asrc;
        logic [3:0] alu;
    } dec_t;

    dec_t       me;
    logic [2:0] mf3;
    logic       m_rw, m_mw, w_rw;
    logic [1:0] m_rs, w_rs;
    int         mcnt;
    bit         mseen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        return tbl[f3];
    endfunction

    function automatic dec_t mdec(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        dec_t d;
        bit shift;
        d = '0;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        case (o)
            7'h03: begin d.rw = 1; d.rs = 2'b01; d.asrc = 1; end
            7'h23: begin d.mw = 1; d.asrc = 1; d.imm = 2'b01; end
            7'h33, 7'h13: begin
                d.rw = 1;
                d.asrc = (o == 7'h13);
                d.alu = base_alu(f3);
                if (o == 7'h33 || shift) begin
                    if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'd9;
                    else if (f7 == 7'h20 && f3 == 3'd0 && o == 7'h33) d.alu = 4'd1;
                    else if (f7 != 7'h00) d.ill = 1;
                end
            end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) d.ill = 1;
                else begin d.br = 1; d.alu = 4'd1; d.imm = 2'b10; end
            end
            7'h6F: begin d.jmp = 1; d.rw = 1; d.rs = 2'b10; d.imm = 2'b11; end
            7'h67: begin d.jmp = 1; d.rw = 1; d.rs = 2'b10; d.asrc = 1; end
            7'h00: ;
            default: d.ill = 1;
        endcase
        if (d.ill) begin d = '0; d.ill = 1; end
        return d;
    endfunction

    function automatic logic bcond(input logic [2:0] f3);
        case (f3)
            3'd0: return ZeroE;
            3'd1: return !ZeroE;
            3'd4: return LtE;
            3'd5: return !LtE;
            3'd6: return LtuE;
            3'd7: return !LtuE;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        dec_t d;
        d = mdec(op, funct3, funct7);
        if (reset) begin
            me = '0; mf3 = '0; m_rw = 0; m_mw = 0; m_rs = 0;
            w_rw = 0; w_rs = 0; mcnt = NRST; mseen = 0;
            return;
        end
        if (!StallE) begin
            w_rw = m_rw; w_rs = m_rs;
            m_rw = me.rw; m_mw = me.mw; m_rs = me.rs;
        end
        if (FlushE || mcnt > 0 || (!StallE && mseen)) begin
            me = '0; mf3 = '0;
        end else if (!StallE) begin
            me = d; mf3 = funct3;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (d.ill && !StallE && !FlushE) mseen = 1;
`endif
        if (mcnt > 0) mcnt--;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic pc;
        pc = me.jmp | (me.br & bcond(mf3));
        chk({tag, "_e"}, {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0},
            {me.alu, me.asrc, pc, me.rs[0]});
        chk({tag, "_mw"}, {RegWriteM, MemWriteM, RegWriteW, ResultSrcW},
            {m_rw, m_mw, w_rw, w_rs});
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk({tag, "_seen"}, IllegalSeen, mseen);
`endif
    endtask

    task automatic do_reset();
        reset = 1; op = 0; funct3 = 0; funct7 = 0; StallE = 0; FlushE = 0;
        step();
        chk("reset_e", {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0}, 0);
        chk("reset_mw", {RegWriteM, MemWriteM, RegWriteW, ResultSrcW}, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("reset_seen", IllegalSeen, 0);
`endif
        reset = 0;
    endtask

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        logic [1:0] imm; logic ill; logic [3:0] alu; logic asrc;
        logic pc; logic rw; logic [1:0] rs; logic mw;
    } vec_t;

    vec_t vt [$];

    initial begin
        dec_t d;
        vt = '{
            '{7'h03,3'd2,7'h00, 2'd0,1'b0,4'd0,1'b1,1'b0,1'b1,2'd1,1'b0},
            '{7'h23,3'd2,7'h00, 2'd1,1'b0,4'd0,1'b1,1'b0,1'b0,2'd0,1'b1},
            '{7'h33,3'd0,7'h00, 2'd0,1'b0,4'd0,1'b0,1'b0,1'b1,2'd0,1'b0},
            '{7'h33,3'd0,7'h20, 2'd0,1'b0,4'd1,1'b0,1'b0,1'b1,2'd0,1'b0},
            '{7'h33,3'd5,7'h20, 2'd0,1'b0,4'd9,1'b0,1'b0,1'b1,2'd0,1'b0},
            '{7'h33,3'd5,7'h00, 2'd0,1'b0,4'd8,1'b0,1'b0,1'b1,2'd0,1'b0},
            '{7'h33,3'd5,7'h01, 2'd0,1'b1,4'd0,1'b0,1'b0,1'b0,2'd0,1'b0},
            '{7'h33,3'd4,7'h00, 2'd0,1'b0,4'd4,1'b0,1'b0,1'b1,2'd0,1'b0},
            '{7'h33,3'd3,7'h00, 2'd0,1'b0,4'd6,1'b0,1'b0,1'b1,2'd0,1'b0},
            '{7'h33,3'd7,7'h20, 2'd0,1'b1,4'd0,1'b0,1'b0,1'b0,2'd0,1'b0},
            '{7'h13,3'd0,7'h20, 2'd0,1'b0,4'd0,1'b1,1'b0,1'b1,2'd0,1'b0},
            '{7'h13,3'd6,7'h7F, 2'd0,1'b0,4'd3,1'b1,1'b0,1'b1,2'd0,1'b0},
            '{7'h13,3'd1,7'h00, 2'd0,1'b0,4'd7,1'b1,1'b0,1'b1,2'd0,1'b0},
            '{7'h13,3'd5,7'h20, 2'd0,1'b0,4'd9,1'b1,1'b0,1'b1,2'd0,1'b0},
            '{7'h13,3'd1,7'h20, 2'd0,1'b1,4'd0,1'b0,1'b0,1'b0,2'd0,1'b0},
            '{7'h13,3'd2,7'h00, 2'd0,1'b0,4'd5,1'b1,1'b0,1'b1,2'd0,1'b0},
            '{7'h63,3'd0,7'h00, 2'd2,1'b0,4'd1,1'b0,1'b0,1'b0,2'd0,1'b0},
            '{7'h63,3'd1,7'h00, 2'd2,1'b0,4'd1,1'b0,1'b1,1'b0,2'd0,1'b0},
            '{7'h63,3'd4,7'h00, 2'd2,1'b0,4'd1,1'b0,1'b0,1'b0,2'd0,1'b0},
            '{7'h63,3'd5,7'h00, 2'd2,1'b0,4'd1,1'b0,1'b1,1'b0,2'd0,1'b0},
            '{7'h63,3'd2,7'h00, 2'd0,1'b1,4'd0,1'b0,1'b0,1'b0,2'd0,1'b0},
            '{7'h6F,3'd0,7'h00, 2'd3,1'b0,4'd0,1'b0,1'b1,1'b1,2'd2,1'b0},
            '{7'h67,3'd0,7'h00, 2'd0,1'b0,4'd0,1'b1,1'b1,1'b1,2'd2,1'b0},
            '{7'h00,3'd0,7'h00, 2'd0,1'b0,4'd0,1'b0,1'b0,1'b0,2'd0,1'b0},
            '{7'h7F,3'd0,7'h00, 2'd0,1'b1,4'd0,1'b0,1'b0,1'b0,2'd0,1'b0},
            '{7'h37,3'd0,7'h00, 2'd0,1'b1,4'd0,1'b0,1'b0,1'b0,2'd0,1'b0}
        };

        // reset, post-reset bubble, lw through the pipe
        do_reset();
        op = 7'h03; funct3 = 3'd2;
        step();
        chk("rstcnt_bubble", {ResultSrcE0, ALUSrcE}, 2'b00);
        step();
        chk("lw_e", {ResultSrcE0, ALUSrcE, ALUControlE}, {1'b1, 1'b1, 4'd0});
        step();
        chk("lw_m", {RegWriteM, MemWriteM}, 2'b10);
        step();
        chk("lw_w", {RegWriteW, ResultSrcW}, 3'b101);

        // decode table, each word held until it fills E, M and W
        foreach (vt[i]) begin
            op = vt[i].op; funct3 = vt[i].f3; funct7 = vt[i].f7;
            #1;
            chk($sformatf("tbl%0d_d", i), {ImmSrcD, IllegalD}, {vt[i].imm, vt[i].ill});
            step(); step(); step();
            chk($sformatf("tbl%0d_e", i), {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0},
                {vt[i].alu, vt[i].asrc, vt[i].pc, vt[i].rs[0]});
            chk($sformatf("tbl%0d_mw", i), {RegWriteM, MemWriteM, RegWriteW, ResultSrcW},
                {vt[i].rw, vt[i].mw, vt[i].rw, vt[i].rs});
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (vt[i].ill) begin
                do_reset();
                for (int k = 0; k < NRST; k++) step();
            end
`endif
        end

        // branch resolution in E
        op = 7'h63; funct3 = 3'd1; funct7 = 0;
        step();
        ZeroE = 0; #1; chk("bne_taken", PCSrcE, 1);
        ZeroE = 1; #1; chk("bne_not", PCSrcE, 0);
        funct3 = 3'd7;
        step();
        LtuE = 1; #1; chk("bgeu_not", PCSrcE, 0);
        LtuE = 0; #1; chk("bgeu_taken", PCSrcE, 1);
        ZeroE = 0;

        // flush wins over stall
        op = 7'h33; funct3 = 3'd0; funct7 = 7'h20;
        step();
        chk("sub_e", ALUControlE, 4'd1);
        op = 7'h23; funct3 = 3'd2; funct7 = 0; FlushE = 1; StallE = 1;
        step();
        chk("flush_e", {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0}, 0);
        FlushE = 0; StallE = 0; op = 0;
        step();
        chk("flush_m", {RegWriteM, MemWriteM}, 2'b00);

        // stall with jal in E
        op = 7'h03; funct3 = 3'd2; step();
        op = 7'h23; step();
        op = 7'h6F; step();
        chk("jal_e", PCSrcE, 1);
        op = 7'h33; funct3 = 3'd0; funct7 = 7'h20; StallE = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("stall%0d_e", k), {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0}, 7'b0000010);
            chk($sformatf("stall%0d_mw", k), {RegWriteM, MemWriteM, RegWriteW, ResultSrcW}, 5'b01101);
        end
        StallE = 0;
        step();
        chk("unstall_e", {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0}, 7'b0001000);
        chk("unstall_mw", {RegWriteM, MemWriteM, RegWriteW, ResultSrcW}, 5'b10000);

`ifdef CTRL_ILLEGAL_TRAP_EN
        do_reset();
        for (int k = 0; k < NRST; k++) step();
        op = 7'h7F; #1;
        chk("trap_illd", IllegalD, 1);
        step();
        chk("trap_seen", IllegalSeen, 1);
        op = 7'h13; funct3 = 0; funct7 = 0;
        step(); step(); step();
        chk("trap_addi_w", RegWriteW, 0);
        do_reset();
`endif

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ops [10];
            ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h00, 7'h33, 7'h13};
            reset  = (i % 50 == 49);
            op     = ($urandom_range(0, 29) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            funct3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1: funct7 = 7'h00;
                2: funct7 = 7'h20;
                default: funct7 = 7'($urandom);
            endcase
            StallE = ($urandom_range(0, 5) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            ZeroE = 1'($urandom); LtE = 1'($urandom); LtuE = 1'($urandom);
            #1;
            d = mdec(op, funct3, funct7);
            chk("rnd_d", {ImmSrcD, IllegalD}, {d.imm, d.ill});
            step();
            check_model("rnd");
        end
        reset = 0; StallE = 0; FlushE = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
